sensor_pwr_seq: RTL and testbench

Power-up / power-down sequencer for the CMOS image sensor, directly downstream of the clocking block. Runs on `clk_sys`. Waits for a stable PLL lock, then:
- enables the sensor supply rails in order;
- gates on the sensor column clock;
- releases sensor reset;
- hands off to the register loader.

It also handles lock loss, disable requests and configuration timeouts with an orderly reverse shutdown.

---
 rtl/sensor_seq_pkg.sv | 24 ++
 rtl/sensor_pwr_seq_sync_2ff.sv | 23 ++
 rtl/sensor_pwr_seq.sv | 190 +++++++++++++++++++
 tb/tb_sensor_pwr_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_seq_pkg.sv
// Shared definitions for the sensor power sequencer: state codes and
// the width of the saturating lock-loss counter.
package sensor_seq_pkg;

  localparam int STATE_W = 4;
  localparam int LLC_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_LOCK = 4'd1,
    ST_DVDD      = 4'd2,
    ST_AVDD      = 4'd3,
    ST_PIX       = 4'd4,
    ST_CLK_ON    = 4'd5,
    ST_RST_REL   = 4'd6,
    ST_CFG       = 4'd7,
    ST_RUN       = 4'd8,
    ST_PWR_DN    = 4'd9,
    ST_FAULT     = 4'd10
  } seq_state_t;

  localparam logic [LLC_W-1:0] LLC_MAX = '1;

endpackage

// File: rtl/sensor_pwr_seq_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous status inputs.
// Both stages clear on reset so the synchronised level starts low.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability time to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sensor_pwr_seq.sv
// Image sensor power sequencer: waits for a stable PLL lock, brings up
// the rails, clock and reset in order, hands off to the register loader
// and shuts everything down in reverse on lock loss, disable or timeout.
module sensor_pwr_seq
  import sensor_seq_pkg::*;
#(
  parameter int T_LOCK_STABLE = 1000,
  parameter int T_PWR         = 5000,
  parameter int T_CLK         = 100,
  parameter int T_RST         = 2000,
  parameter int T_CFG_TO      = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             pll_locked,
  input  logic             en,
  input  logic             cfg_done,
  output logic             dvdd_en,
  output logic             avdd_en,
  output logic             pix_en,
  output logic             clk_sensor_en,
  output logic             sensor_rst_n,
  output logic             cfg_start,
  output logic             ready,
  output logic             fault,
  output logic [LLC_W-1:0] lock_loss_cnt,
  output logic [3:0]       state
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(T_LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(T_CLK - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(T_CFG_TO - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             fault_pend_q, fault_pend_d;
  logic [LLC_W-1:0] llc_q, llc_d;
  logic             lock_s;
  logic             powered_up;
  logic dvdd_d, avdd_d, pix_d, clk_d, rst_n_d, cfg_start_d, ready_d, fault_d;

  sync_2ff u_lock_sync (
    .clk (clk_sys),
    .rst (rst_sys),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign powered_up = (state_q >= ST_DVDD) && (state_q <= ST_RUN);

  // Next-state, delay counter, shutdown phase, fault flag and lock-loss count
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    phase_d      = phase_q;
    fault_pend_d = fault_pend_q;
    llc_d        = llc_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!en)                    state_d = ST_IDLE;
        else if (!lock_s)           cnt_d   = '0;
        else if (cnt_q == LOCK_LAST) state_d = ST_DVDD;
      end
      ST_DVDD:    if (cnt_q == PWR_LAST) state_d = ST_AVDD;
      ST_AVDD:    if (cnt_q == PWR_LAST) state_d = ST_PIX;
      ST_PIX:     if (cnt_q == CLK_LAST) state_d = ST_CLK_ON;
      ST_CLK_ON:  if (cnt_q == RST_LAST) state_d = ST_RST_REL;
      ST_RST_REL: state_d = ST_CFG;
      ST_CFG: begin
        if (cfg_done) begin
          state_d = ST_RUN;
        end else if (cnt_q == CFG_LAST) begin
          state_d      = ST_PWR_DN;
          fault_pend_d = 1'b1;
        end
      end
      ST_RUN: cnt_d = '0;
      ST_PWR_DN: begin
        case (phase_q)
          2'd0: if (cnt_q == CLK_LAST) begin phase_d = 2'd1; cnt_d = '0; end
          2'd1: if (cnt_q == PWR_LAST) begin phase_d = 2'd2; cnt_d = '0; end
          default: begin
            if (cnt_q == PWR_LAST) begin
              if (fault_pend_q) state_d = ST_FAULT;
              else if (en)      state_d = ST_WAIT_LOCK;
              else              state_d = ST_IDLE;
            end
          end
        endcase
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (!en) begin
          state_d      = ST_IDLE;
          fault_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (powered_up && (!lock_s || !en)) begin
      state_d      = ST_PWR_DN;
      fault_pend_d = fault_pend_q;
      if (!lock_s && (llc_q != LLC_MAX)) llc_d = llc_q + LLC_W'(1);
    end
    if (state_d != state_q) begin
      cnt_d   = '0;
      phase_d = '0;
    end
  end

  // Output values for the coming state so outputs switch with the state register
  always_comb begin
    dvdd_d      = 1'b0;
    avdd_d      = 1'b0;
    pix_d       = 1'b0;
    clk_d       = 1'b0;
    rst_n_d     = 1'b0;
    cfg_start_d = 1'b0;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      ST_DVDD:    dvdd_d = 1'b1;
      ST_AVDD:    begin dvdd_d = 1'b1; avdd_d = 1'b1; end
      ST_PIX:     begin dvdd_d = 1'b1; avdd_d = 1'b1; pix_d = 1'b1; end
      ST_CLK_ON:  begin dvdd_d = 1'b1; avdd_d = 1'b1; pix_d = 1'b1; clk_d = 1'b1; end
      ST_RST_REL, ST_CFG, ST_RUN: begin
        dvdd_d      = 1'b1;
        avdd_d      = 1'b1;
        pix_d       = 1'b1;
        clk_d       = 1'b1;
        rst_n_d     = 1'b1;
        cfg_start_d = (state_d == ST_CFG) && (state_q != ST_CFG);
        ready_d     = (state_d == ST_RUN);
      end
      ST_PWR_DN: begin
        pix_d  = pix_en && (phase_d == 2'd0);
        avdd_d = avdd_en && (phase_d != 2'd2);
        dvdd_d = dvdd_en;
      end
      ST_FAULT: fault_d = 1'b1;
      default:  ;
    endcase
  end

  // State, counters and registered outputs; reset drops every rail at once
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      phase_q       <= '0;
      fault_pend_q  <= 1'b0;
      llc_q         <= '0;
      dvdd_en       <= 1'b0;
      avdd_en       <= 1'b0;
      pix_en        <= 1'b0;
      clk_sensor_en <= 1'b0;
      sensor_rst_n  <= 1'b0;
      cfg_start     <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      fault_pend_q  <= fault_pend_d;
      llc_q         <= llc_d;
      dvdd_en       <= dvdd_d;
      avdd_en       <= avdd_d;
      pix_en        <= pix_d;
      clk_sensor_en <= clk_d;
      sensor_rst_n  <= rst_n_d;
      cfg_start     <= cfg_start_d;
      ready         <= ready_d;
      fault         <= fault_d;
    end
  end

  assign state         = state_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Scoreboard bench for sensor_pwr_seq with short delays. The stimulus
// thread queues each expected output change with the cycle it must occur
// on; the monitor pops an entry whenever the observed outputs change.
module tb_sensor_pwr_seq;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       rst_sys;
  logic       pll_locked;
  logic       en;
  logic       cfg_done;
  logic       dvdd_en, avdd_en, pix_en, clk_sensor_en, sensor_rst_n;
  logic       cfg_start, ready, fault;
  logic [3:0] lock_loss_cnt;
  logic [3:0] state;
  logic [15:0] obs;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [15:0] prev;

  sensor_pwr_seq #(
    .T_LOCK_STABLE (4),
    .T_PWR         (8),
    .T_CLK         (2),
    .T_RST         (6),
    .T_CFG_TO      (20),
    .CNT_W         (20)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .pll_locked    (pll_locked),
    .en            (en),
    .cfg_done      (cfg_done),
    .dvdd_en       (dvdd_en),
    .avdd_en       (avdd_en),
    .pix_en        (pix_en),
    .clk_sensor_en (clk_sensor_en),
    .sensor_rst_n  (sensor_rst_n),
    .cfg_start     (cfg_start),
    .ready         (ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  assign obs = {state, dvdd_en, avdd_en, pix_en, clk_sensor_en, sensor_rst_n,
                cfg_start, ready, fault, lock_loss_cnt};

  function automatic logic [15:0] mk(int st, bit dv, bit av, bit px, bit ck,
                                     bit rn, bit cs, bit rd, bit ft, int llc);
    return {4'(st), dv, av, px, ck, rn, cs, rd, ft, 4'(llc)};
  endfunction

  task automatic expectAt(int c, logic [15:0] v, string nm);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic checkOutput(string nm, logic [15:0] act, logic [15:0] exp_v,
                             int act_cyc, int exp_cyc);
    checks++;
    if (act !== exp_v || act_cyc != exp_cyc) begin
      errors++;
      $display("[TB] FAIL %s: got outputs %h at cycle %0d, expected %h at cycle %0d",
               nm, act, act_cyc, exp_v, exp_cyc);
    end
  endtask

  task automatic applyStimulus(bit e, bit lk, bit cd);
    en         = e;
    pll_locked = lk;
    cfg_done   = cd;
  endtask

  task automatic waitUntil(int c);
    while (cyc < c) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Monitor: every observed output change consumes one scoreboard entry
  always @(negedge clk_sys) begin
    exp_t e;
    if (mon_en) begin
      if (obs !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_change: got outputs %h at cycle %0d, expected no change",
                   obs, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput(e.name, obs, e.val, cyc, e.cyc);
        end
        prev = obs;
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL %s: outputs stayed %h at cycle %0d, expected %h at cycle %0d",
                 e.name, obs, cyc, e.val, e.cyc);
      end
    end
  end

  initial begin
    int a, b, c, d, f, g, llc_prev, llc_new;
    exp_t e;
    rst_sys = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("reset_values", obs, 16'h0000, 0, 0);
    rst_sys = 1'b0;
    prev    = 16'h0000;
    mon_en  = 1'b1;

    // Full power-up with lock already stable; stray cfg_done in DVDD ignored
    a = cyc + 6;
    waitUntil(a);
    expectAt(a + 1,  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "up_wait_lock");
    expectAt(a + 5,  mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "up_dvdd");
    expectAt(a + 13, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0), "up_avdd");
    expectAt(a + 21, mk(4, 1, 1, 1, 0, 0, 0, 0, 0, 0), "up_pix");
    expectAt(a + 23, mk(5, 1, 1, 1, 1, 0, 0, 0, 0, 0), "up_clk_on");
    expectAt(a + 29, mk(6, 1, 1, 1, 1, 1, 0, 0, 0, 0), "up_rst_rel");
    expectAt(a + 30, mk(7, 1, 1, 1, 1, 1, 1, 0, 0, 0), "up_cfg_start");
    expectAt(a + 31, mk(7, 1, 1, 1, 1, 1, 0, 0, 0, 0), "up_cfg_start_end");
    expectAt(a + 33, mk(8, 1, 1, 1, 1, 1, 0, 1, 0, 0), "up_ready");
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil(a + 6);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitUntil(a + 7);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil(a + 32);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitUntil(a + 33);
    applyStimulus(1'b1, 1'b1, 1'b0);

    // Lock loss in RUN: ordered shutdown, count 1, back to WAIT_LOCK
    b = a + 36;
    waitUntil(b);
    expectAt(b + 3,  mk(9, 1, 1, 1, 0, 0, 0, 0, 0, 1), "ll_pwr_dn");
    expectAt(b + 5,  mk(9, 1, 1, 0, 0, 0, 0, 0, 0, 1), "ll_pix_off");
    expectAt(b + 13, mk(9, 1, 0, 0, 0, 0, 0, 0, 0, 1), "ll_avdd_off");
    expectAt(b + 21, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ll_wait_lock");
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Lock returns with a one-cycle glitch at count 3, then config timeout
    c = b + 24;
    waitUntil(c);
    expectAt(c + 10, mk(2,  1, 0, 0, 0, 0, 0, 0, 0, 1), "gl_dvdd");
    expectAt(c + 18, mk(3,  1, 1, 0, 0, 0, 0, 0, 0, 1), "gl_avdd");
    expectAt(c + 26, mk(4,  1, 1, 1, 0, 0, 0, 0, 0, 1), "gl_pix");
    expectAt(c + 28, mk(5,  1, 1, 1, 1, 0, 0, 0, 0, 1), "gl_clk_on");
    expectAt(c + 34, mk(6,  1, 1, 1, 1, 1, 0, 0, 0, 1), "gl_rst_rel");
    expectAt(c + 35, mk(7,  1, 1, 1, 1, 1, 1, 0, 0, 1), "to_cfg_start");
    expectAt(c + 36, mk(7,  1, 1, 1, 1, 1, 0, 0, 0, 1), "to_cfg_wait");
    expectAt(c + 55, mk(9,  1, 1, 1, 0, 0, 0, 0, 0, 1), "to_pwr_dn");
    expectAt(c + 57, mk(9,  1, 1, 0, 0, 0, 0, 0, 0, 1), "to_pix_off");
    expectAt(c + 65, mk(9,  1, 0, 0, 0, 0, 0, 0, 0, 1), "to_avdd_off");
    expectAt(c + 73, mk(10, 0, 0, 0, 0, 0, 0, 0, 1, 1), "to_fault");
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil(c + 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil(c + 4);
    applyStimulus(1'b1, 1'b1, 1'b0);

    // Releasing en clears the fault
    d = c + 75;
    waitUntil(d);
    expectAt(d + 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "fault_clear");
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Asynchronous reset in AVDD drops everything mid-cycle
    f = d + 3;
    waitUntil(f);
    expectAt(f + 1,  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "rs_wait_lock");
    expectAt(f + 5,  mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 1), "rs_dvdd");
    expectAt(f + 13, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 1), "rs_avdd");
    expectAt(f + 15, 16'h0000, "rs_reset_seen");
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil(f + 15);
    #2;
    rst_sys = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("async_reset", obs, 16'h0000, 0, 0);
    waitUntil(f + 17);
    rst_sys = 1'b0;

    // Sixteen lock losses in DVDD, each together with en dropping
    g = f + 22;
    for (int i = 0; i < 16; i++) begin
      llc_prev = i;
      llc_new  = (i + 1 > 15) ? 15 : i + 1;
      waitUntil(g);
      expectAt(g + 1,  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, llc_prev), $sformatf("sat%0d_wait_lock", i));
      expectAt(g + 5,  mk(2, 1, 0, 0, 0, 0, 0, 0, 0, llc_prev), $sformatf("sat%0d_dvdd", i));
      expectAt(g + 8,  mk(9, 1, 0, 0, 0, 0, 0, 0, 0, llc_new),  $sformatf("sat%0d_pwr_dn", i));
      expectAt(g + 26, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, llc_new),  $sformatf("sat%0d_idle", i));
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitUntil(g + 5);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitUntil(g + 7);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitUntil(g + 26);
      applyStimulus(1'b0, 1'b1, 1'b0);
      g = g + 30;
    end

    waitUntil(g + 5);
    mon_en = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: never observed, expected %h at cycle %0d", e.name, e.val, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
